// File: rtl/nova_pkg.sv
// Shared encodings for the Nova3201 control sequencer: fields, opcodes, functs,
// ALU operation codes and the sequencer state type.
package nova_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int TGT_MSB = 25;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [5:0] ALU_ADD  = 6'h00;
    localparam logic [5:0] ALU_SUB  = 6'h01;
    localparam logic [5:0] ALU_AND  = 6'h02;
    localparam logic [5:0] ALU_OR   = 6'h03;
    localparam logic [5:0] ALU_XOR  = 6'h04;
    localparam logic [5:0] ALU_ADDI = 6'h10;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALTED
    } state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: maps opcode/funct to an ALU operation
// and the instruction-class flags used by the sequencer.
module instr_decode
    import nova_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [5:0] o_alu_op,
    output logic       o_dest_is_rd,
    output logic       o_writes_reg,
    output logic       o_is_jump,
    output logic       o_is_halt,
    output logic       o_is_illegal
);

    always_comb begin
        o_alu_op     = ALU_ADD;
        o_dest_is_rd = 1'b0;
        o_writes_reg = 1'b0;
        o_is_jump    = 1'b0;
        o_is_halt    = 1'b0;
        o_is_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_dest_is_rd = 1'b1;
                o_writes_reg = 1'b1;
                case (i_funct)
                    FN_ADD:  o_alu_op = ALU_ADD;
                    FN_SUB:  o_alu_op = ALU_SUB;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_OR:   o_alu_op = ALU_OR;
                    FN_XOR:  o_alu_op = ALU_XOR;
                    default: begin
                        o_writes_reg = 1'b0;
                        o_is_illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                o_alu_op     = ALU_ADDI;
                o_writes_reg = 1'b1;
            end
            OP_J:    o_is_jump    = 1'b1;
            OP_HALT: o_is_halt    = 1'b1;
            default: o_is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_seq.sv
// Nova3201 multi-cycle sequencer: FETCH -> DECODE -> EXEC -> WB around an
// external combinational ALU and register file; owns PC, jumps and halt.
module cpu_seq
    import nova_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rf_ra1,
    output logic [4:0]  rf_ra2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    output logic [5:0]  alu_op,
    output logic [31:0] alu_rs,
    output logic [31:0] alu_rt,
    output logic [15:0] alu_imm16,
    output logic [25:0] alu_target,
    input  logic [31:0] alu_result,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [31:0] pc,
    output logic        halted,
    output logic        illegal
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_ir;
    logic [31:0] r_pc;
    logic        r_pend;
    logic [5:0]  r_alu_op;
    logic [31:0] r_alu_rs;
    logic [31:0] r_alu_rt;
    logic [4:0]  r_wa;
    logic [31:0] r_wd;
    logic        r_halted;
    logic        r_illegal;

    logic [5:0]  w_alu_op;
    logic        w_dest_is_rd;
    logic        w_writes_reg;
    logic        w_is_jump;
    logic        w_is_halt;
    logic        w_is_illegal;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_pc;
    logic [4:0]  w_dest;

    instr_decode u_decode (
        .i_opcode     (r_ir[OPC_MSB:OPC_LSB]),
        .i_funct      (r_ir[FN_MSB:FN_LSB]),
        .o_alu_op     (w_alu_op),
        .o_dest_is_rd (w_dest_is_rd),
        .o_writes_reg (w_writes_reg),
        .o_is_jump    (w_is_jump),
        .o_is_halt    (w_is_halt),
        .o_is_illegal (w_is_illegal)
    );

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_jump_pc  = {w_pc_plus4[31:28], r_ir[TGT_MSB:0], 2'b00};
    assign w_dest     = w_dest_is_rd ? r_ir[RD_MSB:RD_LSB] : r_ir[RT_MSB:RT_LSB];

    // A raised request is held by r_pend until ack even if run drops; the
    // rst_n term keeps the request low while reset is asserted.
    assign imem_req   = rst_n && (r_state == FETCH) && (run || r_pend);
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign rf_ra1     = r_ir[RS_MSB:RS_LSB];
    assign rf_ra2     = r_ir[RT_MSB:RT_LSB];
    assign alu_op     = r_alu_op;
    assign alu_rs     = r_alu_rs;
    assign alu_rt     = r_alu_rt;
    assign alu_imm16  = r_ir[IMM_MSB:0];
    assign alu_target = r_ir[TGT_MSB:0];
    assign rf_we      = (r_state == WB) && (r_wa != 5'd0);
    assign rf_wa      = r_wa;
    assign rf_wd      = r_wd;
    assign halted     = r_halted;
    assign illegal    = r_illegal;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH: if (imem_req && imem_ack) w_state_nxt = DECODE;
            DECODE: begin
                if (w_is_illegal || w_is_halt) w_state_nxt = HALTED;
                else if (w_writes_reg)         w_state_nxt = EXEC;
                else                           w_state_nxt = FETCH;
            end
            EXEC:    w_state_nxt = WB;
            WB:      w_state_nxt = FETCH;
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_ir      <= 32'h0;
            r_pc      <= RESET_PC;
            r_pend    <= 1'b0;
            r_alu_op  <= 6'h0;
            r_alu_rs  <= 32'h0;
            r_alu_rt  <= 32'h0;
            r_wa      <= 5'd0;
            r_wd      <= 32'h0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                FETCH: begin
                    if (imem_req) begin
                        if (imem_ack) begin
                            r_ir   <= imem_rdata;
                            r_pend <= 1'b0;
                        end else begin
                            r_pend <= 1'b1;
                        end
                    end
                end
                DECODE: begin
                    r_alu_rs <= rf_rd1;
                    r_alu_rt <= rf_rd2;
                    r_alu_op <= w_alu_op;
                    if (w_is_jump) r_pc <= w_jump_pc;
                    if (w_is_halt || w_is_illegal) r_halted <= 1'b1;
                    if (w_is_illegal) r_illegal <= 1'b1;
                end
                EXEC: begin
                    r_wd <= alu_result;
                    r_wa <= w_dest;
                end
                WB:      r_pc <= w_pc_plus4;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq: instruction memory, register file and ALU
// are modelled here; random programs are checked against an ISA-level model.
`timescale 1ns/1ps
module tb_cpu_seq;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] I_HALT = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [4:0]  rf_ra1, rf_ra2;
    logic [31:0] rf_rd1, rf_rd2;
    logic [5:0]  alu_op;
    logic [31:0] alu_rs, alu_rt;
    logic [15:0] alu_imm16;
    logic [25:0] alu_target;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] pc;
    logic        halted, illegal;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [256];
    logic [31:0] rf  [32];
    int          ack_delay = 0;
    bit          rand_ack = 1'b0;
    logic [31:0] fetch_log [$];
    logic [36:0] wr_log [$];
    int          req_cycles = 0;
    int          we_cycles = 0;
    bit          unstable = 1'b0;

    cpu_seq #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .alu_op(alu_op), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_imm16(alu_imm16),
        .alu_target(alu_target), .alu_result(alu_result),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pc(pc), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign rf_rd1 = rf[rf_ra1];
    assign rf_rd2 = rf[rf_ra2];

    always_comb begin
        case (alu_op)
            6'h00:   alu_result = alu_rs + alu_rt;
            6'h01:   alu_result = alu_rs - alu_rt;
            6'h02:   alu_result = alu_rs & alu_rt;
            6'h03:   alu_result = alu_rs | alu_rt;
            6'h04:   alu_result = alu_rs ^ alu_rt;
            6'h10:   alu_result = alu_rs + {{16{alu_imm16[15]}}, alu_imm16};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    // Memory responder, register-file writer and activity logger, all on the falling edge.
    task automatic monitor();
        int          wait_cnt = 0;
        bit          prev_pend = 1'b0;
        logic [31:0] pend_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                imem_ack = 1'b0;
                wait_cnt = 0;
                prev_pend = 1'b0;
            end else begin
                if (rf_we) begin
                    we_cycles++;
                    wr_log.push_back({rf_wa, rf_wd});
                    if (rf_wa != 5'd0) rf[rf_wa] = rf_wd;
                end
                if (imem_req) begin
                    req_cycles++;
                    if (prev_pend && imem_addr !== pend_addr) unstable = 1'b1;
                    if (wait_cnt >= ack_delay) begin
                        imem_ack = 1'b1;
                        imem_rdata = mem[imem_addr[9:2]];
                        fetch_log.push_back(imem_addr);
                        wait_cnt = 0;
                        prev_pend = 1'b0;
                        if (rand_ack) ack_delay = $urandom_range(0, 2);
                    end else begin
                        imem_ack = 1'b0;
                        wait_cnt++;
                        prev_pend = 1'b1;
                        pend_addr = imem_addr;
                    end
                end else begin
                    if (prev_pend) unstable = 1'b1;
                    imem_ack = 1'b0;
                    wait_cnt = 0;
                    prev_pend = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic prep();
        run = 1'b0;
        rst_n = 1'b0;
        rand_ack = 1'b0;
        ack_delay = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        fetch_log.delete();
        wr_log.delete();
        req_cycles = 0;
        we_cycles = 0;
        unstable = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic wait_halt(input int max_cyc, input bit toggle_run, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (toggle_run) run = ($urandom_range(0, 3) != 0);
            step(1);
        end
        run = 1'b0;
    endtask

    task automatic test_reset();
        run = 1'b1;
        rst_n = 1'b0;
        step(2);
        checks++;
        if (imem_req !== 1'b0 || rf_we !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl req=%b we=%b halted=%b illegal=%b expected all 0",
                     imem_req, rf_we, halted, illegal);
        end
        checks++;
        if (pc !== RST_PC || imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL reset_pc pc=%h addr=%h expected %h", pc, imem_addr, RST_PC);
        end
        checks++;
        if (rf_wa !== 5'd0 || rf_wd !== 32'h0 || alu_op !== 6'h0 || alu_rs !== 32'h0 || alu_rt !== 32'h0) begin
            failures++;
            $display("FAIL reset_data wa=%h wd=%h op=%h rs=%h rt=%h expected all 0",
                     rf_wa, rf_wd, alu_op, alu_rs, alu_rt);
        end
        run = 1'b0;
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_add();
        prep();
        mem[0] = 32'h0022_1820;
        mem[1] = I_HALT;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        run = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL add_first_req req=%b addr=%h expected 1/0", imem_req, imem_addr);
        end
        step(1);
        checks++;
        if (rf_ra1 !== 5'd1 || rf_ra2 !== 5'd2) begin
            failures++;
            $display("FAIL add_decode_ra ra1=%0d ra2=%0d expected 1/2", rf_ra1, rf_ra2);
        end
        step(1);
        checks++;
        if (alu_op !== 6'h00 || alu_rs !== 32'd5 || alu_rt !== 32'd7) begin
            failures++;
            $display("FAIL add_exec op=%h rs=%0d rt=%0d expected 0/5/7", alu_op, alu_rs, alu_rt);
        end
        step(1);
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'd12 || pc !== 32'h0) begin
            failures++;
            $display("FAIL add_wb we=%b wa=%0d wd=%0d pc=%h expected 1/3/12/0", rf_we, rf_wa, rf_wd, pc);
        end
        step(1);
        checks++;
        if (pc !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h4 || rf_we !== 1'b0) begin
            failures++;
            $display("FAIL add_next_fetch pc=%h req=%b addr=%h we=%b expected 4/1/4/0",
                     pc, imem_req, imem_addr, rf_we);
        end
    endtask

    task automatic test_addi();
        prep();
        mem[0] = 32'h2022_FFFF;
        mem[1] = I_HALT;
        rf[1] = 32'h0;
        run = 1'b1;
        step(2);
        checks++;
        if (alu_op !== 6'h10 || alu_imm16 !== 16'hFFFF || alu_rs !== 32'h0) begin
            failures++;
            $display("FAIL addi_exec op=%h imm=%h rs=%h expected 10/ffff/0", alu_op, alu_imm16, alu_rs);
        end
        step(1);
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd2 || rf_wd !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL addi_wb we=%b wa=%0d wd=%h expected 1/2/ffffffff", rf_we, rf_wa, rf_wd);
        end
    endtask

    task automatic test_jump();
        bit ok;
        prep();
        mem[0]   = 32'h0800_0080;
        mem[128] = 32'h0800_0040;
        mem[64]  = I_HALT;
        run = 1'b1;
        step(1);
        checks++;
        if (alu_target !== 26'h80) begin
            failures++;
            $display("FAIL jump_target target=%h expected 80", alu_target);
        end
        step(1);
        checks++;
        if (pc !== 32'h200 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL jump_latency pc=%h req=%b addr=%h expected 200/1/200", pc, imem_req, imem_addr);
        end
        wait_halt(60, 1'b0, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL jump_halt_timeout halted=%b expected 1", halted);
        end
        checks++;
        if (fetch_log.size() != 3 || fetch_log[0] !== 32'h0 || fetch_log[1] !== 32'h200 || fetch_log[2] !== 32'h100) begin
            failures++;
            $display("FAIL jump_fetch_seq n=%0d expected fetches 0,200,100", fetch_log.size());
        end
        checks++;
        if (we_cycles != 0 || pc !== 32'h100 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL jump_end we_cycles=%0d pc=%h illegal=%b expected 0/100/0", we_cycles, pc, illegal);
        end
    endtask

    task automatic test_illegal();
        int rc, wc;
        prep();
        mem[0] = 32'hF800_0000;
        run = 1'b1;
        step(1);
        checks++;
        if (halted !== 1'b0) begin
            failures++;
            $display("FAIL illegal_early halted=%b expected 0", halted);
        end
        step(1);
        checks++;
        if (halted !== 1'b1 || illegal !== 1'b1) begin
            failures++;
            $display("FAIL illegal_flags halted=%b illegal=%b expected 1/1", halted, illegal);
        end
        rc = req_cycles;
        wc = we_cycles;
        step(20);
        checks++;
        if (req_cycles != rc || we_cycles != wc || imem_req !== 1'b0 || halted !== 1'b1) begin
            failures++;
            $display("FAIL illegal_terminal req_cycles=%0d/%0d we_cycles=%0d/%0d halted=%b expected no activity",
                     req_cycles, rc, we_cycles, wc, halted);
        end
        run = 1'b0;
    endtask

    task automatic test_wait_run();
        int  bad;
        bit  ok;
        prep();
        mem[0] = 32'h0022_1820;
        mem[1] = I_HALT;
        rf[1] = 32'd9;
        rf[2] = 32'd4;
        ack_delay = 3;
        run = 1'b1;
        step(1);
        run = 1'b0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0) bad++;
            step(1);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL wait_hold bad_cycles=%0d expected 0", bad);
        end
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (we_cycles >= 1) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_wb_timeout we_cycles=%0d expected 1", we_cycles);
        end
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (imem_req !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || req_cycles != 4) begin
            failures++;
            $display("FAIL wait_run_low bad_cycles=%0d req_cycles=%0d expected 0/4", bad, req_cycles);
        end
        ack_delay = 0;
        run = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            failures++;
            $display("FAIL wait_resume req=%b addr=%h expected 1/4", imem_req, imem_addr);
        end
        wait_halt(40, 1'b0, ok);
        checks++;
        if (!ok || wr_log.size() != 1 || wr_log[0] !== {5'd3, 32'd13}) begin
            failures++;
            $display("FAIL wait_result halted=%b writes=%0d expected halted with one write r3=13", halted, wr_log.size());
        end
        checks++;
        if (unstable) begin
            failures++;
            $display("FAIL wait_stable unstable=%b expected 0", unstable);
        end
    endtask

    task automatic test_r0_async_reset();
        prep();
        mem[0] = 32'h0022_0020;
        mem[1] = 32'h0022_1820;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        run = 1'b1;
        step(3);
        checks++;
        if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd12) begin
            failures++;
            $display("FAIL r0_wb we=%b wa=%0d wd=%0d expected 0/0/12", rf_we, rf_wa, rf_wd);
        end
        step(1);
        checks++;
        if (pc !== 32'h4 || we_cycles != 0) begin
            failures++;
            $display("FAIL r0_pc pc=%h we_cycles=%0d expected 4/0", pc, we_cycles);
        end
        step(2);
        checks++;
        if (alu_rs !== 32'd5 || alu_rt !== 32'd7) begin
            failures++;
            $display("FAIL r0_second_exec rs=%0d rt=%0d expected 5/7", alu_rs, alu_rt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== RST_PC || imem_req !== 1'b0 || rf_we !== 1'b0 || alu_op !== 6'h0 ||
            alu_rs !== 32'h0 || alu_rt !== 32'h0 || rf_wa !== 5'd0 || rf_wd !== 32'h0 ||
            halted !== 1'b0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL async_reset pc=%h req=%b we=%b rs=%h rt=%h wd=%h expected reset values",
                     pc, imem_req, rf_we, alu_rs, alu_rt, rf_wd);
        end
        step(1);
        run = 1'b0;
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_random(input int iter);
        localparam int N = 20;
        logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
        logic [5:0]  bad_ops [5] = '{6'h01, 6'h04, 6'h0C, 6'h23, 6'h3E};
        logic [31:0] mrf [32];
        logic [31:0] exp_fetch [$];
        logic [36:0] exp_wr [$];
        logic [31:0] pc_m, ins, a, b, r, nxt;
        logic [4:0]  s, t, d;
        logic [5:0]  op, fn;
        bit          exp_ill, ok;
        int          k, bad;

        prep();
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        for (int i = 0; i < N - 1; i++) begin
            k = $urandom_range(0, 9);
            s = 5'($urandom_range(0, 7));
            t = 5'($urandom_range(0, 7));
            d = 5'($urandom_range(0, 7));
            if (k <= 5)
                mem[i] = enc_r(s, t, d, fns[$urandom_range(0, 4)]);
            else if (k <= 7 || i + 2 > N - 1)
                mem[i] = enc_i(6'h08, s, t, 16'($urandom));
            else
                mem[i] = {6'h02, 26'(i + 2)};
        end
        case (iter % 3)
            0:       mem[N-1] = I_HALT;
            1:       mem[N-1] = {bad_ops[$urandom_range(0, 4)], 26'($urandom)};
            default: mem[N-1] = enc_r(5'd1, 5'd2, 5'd3, 6'h21);
        endcase

        for (int i = 0; i < 32; i++) mrf[i] = rf[i];
        pc_m = RST_PC;
        exp_ill = 1'b0;
        for (int st = 0; st < 200; st++) begin
            ins = mem[pc_m[9:2]];
            exp_fetch.push_back(pc_m);
            op = ins[31:26];
            fn = ins[5:0];
            a = mrf[ins[25:21]];
            b = mrf[ins[20:16]];
            if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h26)) begin
                if (fn == 6'h20)      r = a + b;
                else if (fn == 6'h22) r = a - b;
                else if (fn == 6'h24) r = a & b;
                else if (fn == 6'h25) r = a | b;
                else                  r = a ^ b;
                d = ins[15:11];
                if (d != 5'd0) begin
                    exp_wr.push_back({d, r});
                    mrf[d] = r;
                end
                pc_m = pc_m + 32'd4;
            end else if (op == 6'h08) begin
                r = a + {{16{ins[15]}}, ins[15:0]};
                d = ins[20:16];
                if (d != 5'd0) begin
                    exp_wr.push_back({d, r});
                    mrf[d] = r;
                end
                pc_m = pc_m + 32'd4;
            end else if (op == 6'h02) begin
                nxt = pc_m + 32'd4;
                pc_m = {nxt[31:28], ins[25:0], 2'b00};
            end else begin
                exp_ill = (op != 6'h3F);
                break;
            end
        end

        rand_ack = 1'b1;
        ack_delay = $urandom_range(0, 2);
        run = 1'b1;
        wait_halt(1500, 1'b1, ok);
        rand_ack = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rand%0d_halt_timeout halted=%b expected 1", iter, halted);
        end
        checks++;
        if (illegal !== exp_ill || pc !== pc_m) begin
            failures++;
            $display("FAIL rand%0d_end illegal=%b pc=%h expected %b/%h", iter, illegal, pc, exp_ill, pc_m);
        end
        bad = 0;
        if (wr_log.size() != exp_wr.size()) bad++;
        else for (int i = 0; i < exp_wr.size(); i++) if (wr_log[i] !== exp_wr[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rand%0d_writes got=%0d expected=%0d bad=%0d", iter, wr_log.size(), exp_wr.size(), bad);
        end
        bad = 0;
        if (fetch_log.size() != exp_fetch.size()) bad++;
        else for (int i = 0; i < exp_fetch.size(); i++) if (fetch_log[i] !== exp_fetch[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rand%0d_fetches got=%0d expected=%0d bad=%0d", iter, fetch_log.size(), exp_fetch.size(), bad);
        end
        checks++;
        if (unstable) begin
            failures++;
            $display("FAIL rand%0d_req_stable unstable=%b expected 0", iter, unstable);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_add();
        test_addi();
        test_jump();
        test_illegal();
        test_wait_run();
        test_r0_async_reset();
        for (int it = 0; it < 6; it++) test_random(it);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
Multi-cycle control sequencer for the Nova3201 core.
- Fetches instructions over a simple request/acknowledge instruction-memory port.
- Decodes each instruction and reads operands from the register file.
- Drives the shared combinational ALU (alu_op/rs/rt/imm16/target) for one cycle, then writes the result back.
- Owns the PC, jumps, the halt condition and illegal-instruction detection.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  permits new fetches when high
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (equals pc)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
rf_ra1  out  5  register-file read address A (ir[25:21])
rf_ra2  out  5  register-file read address B (ir[20:16])
rf_rd1  in  32  read data A (combinational)
rf_rd2  in  32  read data B (combinational)
alu_op  out  6  ALU operation select
alu_rs  out  32  ALU operand rs
alu_rt  out  32  ALU operand rt
alu_imm16  out  16  ALU immediate (ir[15:0])
alu_target  out  26  ALU jump target (ir[25:0])
alu_result  in  32  ALU result (combinational)
rf_we  out  1  register write strobe, one-cycle pulse
rf_wa  out  5  write address
rf_wd  out  32  write data
pc  out  32  current PC
halted  out  1  sticky; core stopped
illegal  out  1  sticky; halt was caused by an illegal instruction

Behaviour:
- Reset values:
  - pc=RESET_PC.
  - All other outputs 0: imem_req, rf_we, rf_wa, rf_wd, alu_op, alu_rs, alu_rt, halted, illegal.
  - Internal ir=0. State=FETCH.
- Reset is asynchronous. Asserting it mid-instruction abandons any outstanding fetch, and the memory side must tolerate this.
- Encoding:
  - opcode=ir[31:26], rs=ir[25:21], rt=ir[20:16], rd=ir[15:11], funct=ir[5:0].
  - opcode 0x00 is R-type; funct selects the ALU op: 0x20 ADD→0x0, 0x22 SUB→0x1, 0x24 AND→0x2, 0x25 OR→0x3, 0x26 XOR→0x4. Destination is rd.
  - opcode 0x08 is ADDI → ALU 0x10. Destination is rt.
  - opcode 0x02 is J. opcode 0x3F is HALT.
  - Any other opcode, or an unlisted funct, is illegal.
- FETCH:
  - imem_req=run and no request is outstanding, or a request is outstanding.
  - Once raised, imem_req and imem_addr hold until imem_ack, regardless of run.
  - imem_ack may arrive in the same cycle as the request.
  - On ack: ir<=imem_rdata, then go to DECODE.
- DECODE:
  - rf_ra1/rf_ra2 are driven from ir.
  - Latch alu_rs<=rf_rd1, alu_rt<=rf_rd2, alu_op<=decoded op.
  - ALU op → EXEC.
  - J: pc<={pc_plus4[31:28], ir[25:0], 2'b00}, then FETCH.
  - HALT: halted<=1, then HALTED.
  - Illegal: halted<=1, illegal<=1, then HALTED.
- EXEC: the ALU is combinational. Latch rf_wd<=alu_result and rf_wa<=destination, then WB.
- WB:
  - rf_we=1 for exactly one cycle, except that it stays 0 when the destination is r0.
  - pc<=pc+4 (wraps modulo 2^32), then FETCH.
- HALTED: terminal. No imem_req, no rf_we. Left only by reset.
- Latency with zero-wait memory: ALU instruction 4 cycles, J 2 cycles, HALT/illegal 2 cycles to halted=1.
- The ALU's 0xDEADBEEF default is never reached, because illegal ops never enter EXEC.

Decomposition:
- Package nova_pkg holds:
  - opcode, funct and ALU-op localparams;
  - the state enum FETCH/DECODE/EXEC/WB/HALTED;
  - the instruction field bit positions.
- One combinational sub-module, instr_decode, maps ir to: alu_op, dest_is_rd, writes_reg, is_jump, is_halt, is_illegal.

Test Plan:
- ADD r3,r1,r2 (0x00221820), r1=5, r2=7, zero-wait ack → alu_op=0x0 in EXEC; rf_we pulse with rf_wa=3, rf_wd=12; pc 0→4; next imem_req 4 cycles after the first.
- ADDI r2,r1,-1 (0x2022FFFF), r1=0 → alu_op=0x10; rf_wa=2; rf_wd=0xFFFFFFFF.
- pc=0x200, J (0x08000040) → next imem_addr=0x100; rf_we never asserted.
- Instruction 0xF8000000 (opcode 0x3E) → halted=1 and illegal=1 two cycles after ack; no further imem_req or rf_we for 20 cycles.
- Ack delayed 3 cycles, with run dropped during the wait → imem_req/imem_addr stable until ack; after WB, no new imem_req while run=0; the fetch resumes when run=1.
- ADD r0,r1,r2 → rf_we stays 0 and pc advances by 4. rst_n asserted during EXEC → all outputs at reset values immediately, asynchronously, and pc=RESET_PC.
